// File: rtl/reorder_buffer_pkg.sv
// Shared core constants for the reorder buffer, rename and reservation stations.
// Geometry, CDB port map and the ROB entry record.
package reorder_buffer_pkg;

    localparam int ROB_DEPTH = 8;
    localparam int ROB_TAG_W = 3;
    localparam int CDB_PORTS = 6;

    localparam int CDB_ADD1  = 0;
    localparam int CDB_ADD2  = 1;
    localparam int CDB_ADD3  = 2;
    localparam int CDB_MULT1 = 3;
    localparam int CDB_MULT2 = 4;
    localparam int CDB_LS    = 5;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        wen;
        logic [4:0]  rd;
        logic [31:0] data;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_cdb_match.sv
// Priority tag match of one ROB tag against all CDB ports.
// The lowest-numbered matching port supplies the data.
module rob_cdb_match #(
    parameter int TAG_W = 3,
    parameter int NCDB  = 6
) (
    input  logic [TAG_W-1:0]      tag,
    input  logic [NCDB-1:0]       cdb_valid,
    input  logic [NCDB*TAG_W-1:0] cdb_tag,
    input  logic [NCDB*32-1:0]    cdb_data,
    output logic                  hit,
    output logic [31:0]           data
);

    // Scan high to low so the lowest matching port is the last writer.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int p = NCDB - 1; p >= 0; p--) begin
            if (cdb_valid[p] && cdb_tag[p*TAG_W +: TAG_W] == tag) begin
                hit  = 1'b1;
                data = cdb_data[p*32 +: 32];
            end
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer fed by a multi-port result bus.
// Allocates at tail, captures results by tag, commits one entry per cycle at head.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int DEPTH = ROB_DEPTH,
    parameter int TAG_W = ROB_TAG_W,
    parameter int NCDB  = CDB_PORTS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alloc_valid,
    input  logic [4:0]            alloc_rd,
    input  logic                  alloc_wen,
    output logic                  alloc_ready,
    output logic [TAG_W-1:0]      alloc_tag,
    input  logic [NCDB-1:0]       cdb_valid,
    input  logic [NCDB*TAG_W-1:0] cdb_tag,
    input  logic [NCDB*32-1:0]    cdb_data,
    input  logic [TAG_W-1:0]      q_tag1,
    input  logic [TAG_W-1:0]      q_tag2,
    output logic                  q_done1,
    output logic                  q_done2,
    output logic [31:0]           q_data1,
    output logic [31:0]           q_data2,
    input  logic                  flush,
    output logic                  commit_valid,
    output logic                  commit_wen,
    output logic [4:0]            commit_idx,
    output logic [31:0]           commit_data,
    output logic [TAG_W-1:0]      commit_tag,
    output logic                  empty
);

    rob_entry_t ent [DEPTH];

    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic [TAG_W:0]   count;

    logic             alloc_fire;
    logic             commit_fire;
    logic [DEPTH-1:0] cap_hit;
    logic [31:0]      cap_data [DEPTH];

    logic             qh1, qh2;
    logic [31:0]      qd1, qd2;

    assign alloc_ready = count < (TAG_W+1)'(DEPTH);
    assign alloc_tag   = tail;
    assign empty       = count == '0;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign commit_fire = ent[head].busy && ent[head].done;

    for (genvar i = 0; i < DEPTH; i++) begin : g_cap
        rob_cdb_match #(
            .TAG_W (TAG_W),
            .NCDB  (NCDB)
        ) u_cap (
            .tag       (TAG_W'(i)),
            .cdb_valid (cdb_valid),
            .cdb_tag   (cdb_tag),
            .cdb_data  (cdb_data),
            .hit       (cap_hit[i]),
            .data      (cap_data[i])
        );
    end

    rob_cdb_match #(
        .TAG_W (TAG_W),
        .NCDB  (NCDB)
    ) u_q1 (
        .tag       (q_tag1),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .hit       (qh1),
        .data      (qd1)
    );

    rob_cdb_match #(
        .TAG_W (TAG_W),
        .NCDB  (NCDB)
    ) u_q2 (
        .tag       (q_tag2),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .hit       (qh2),
        .data      (qd2)
    );

    // Operand lookup: live bus result first, then a completed entry.
    always_comb begin
        q_done1 = 1'b0;
        q_data1 = '0;
        q_done2 = 1'b0;
        q_data2 = '0;
        if (qh1) begin
            q_done1 = 1'b1;
            q_data1 = qd1;
        end else if (ent[q_tag1].busy && ent[q_tag1].done) begin
            q_done1 = 1'b1;
            q_data1 = ent[q_tag1].data;
        end
        if (qh2) begin
            q_done2 = 1'b1;
            q_data2 = qd2;
        end else if (ent[q_tag2].busy && ent[q_tag2].done) begin
            q_done2 = 1'b1;
            q_data2 = ent[q_tag2].data;
        end
    end

    // Entry state: retire at head, capture results, allocate at tail.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (commit_fire && head == TAG_W'(i)) begin
                    ent[i].busy <= 1'b0;
                end
                if (cap_hit[i] && ent[i].busy) begin
                    ent[i].done <= 1'b1;
                    ent[i].data <= cap_data[i];
                end
                if (alloc_fire && tail == TAG_W'(i)) begin
                    ent[i].busy <= 1'b1;
                    ent[i].done <= 1'b0;
                    ent[i].rd   <= alloc_rd;
                    ent[i].wen  <= alloc_wen;
                end
            end
        end
    end

    // Pointers and occupancy; indices wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (alloc_fire) begin
                tail <= tail + 1'b1;
            end
            if (commit_fire) begin
                head <= head + 1'b1;
            end
            if (alloc_fire && !commit_fire) begin
                count <= count + 1'b1;
            end else if (!alloc_fire && commit_fire) begin
                count <= count - 1'b1;
            end
        end
    end

    // Registered commit port; payload holds when nothing retires.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            commit_valid <= 1'b0;
            commit_wen   <= 1'b0;
            commit_idx   <= '0;
            commit_data  <= '0;
            commit_tag   <= '0;
        end else if (flush || !commit_fire) begin
            commit_valid <= 1'b0;
            commit_wen   <= 1'b0;
        end else begin
            commit_valid <= 1'b1;
            commit_wen   <= ent[head].wen;
            commit_idx   <= ent[head].rd;
            commit_data  <= ent[head].data;
            commit_tag   <= head;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: vector table plus multi-cycle sequences.
// Expected values are hand-computed constants.
module tb_reorder_buffer;

    localparam int TW = 3;
    localparam int NC = 6;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             alloc_valid;
    logic [4:0]       alloc_rd;
    logic             alloc_wen;
    logic             alloc_ready;
    logic [TW-1:0]    alloc_tag;
    logic [NC-1:0]    cdb_valid;
    logic [NC*TW-1:0] cdb_tag;
    logic [NC*32-1:0] cdb_data;
    logic [TW-1:0]    q_tag1, q_tag2;
    logic             q_done1, q_done2;
    logic [31:0]      q_data1, q_data2;
    logic             flush;
    logic             commit_valid;
    logic             commit_wen;
    logic [4:0]       commit_idx;
    logic [31:0]      commit_data;
    logic [TW-1:0]    commit_tag;
    logic             empty;

    int n_tests = 0;
    int n_fail  = 0;

    reorder_buffer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alloc_valid  (alloc_valid),
        .alloc_rd     (alloc_rd),
        .alloc_wen    (alloc_wen),
        .alloc_ready  (alloc_ready),
        .alloc_tag    (alloc_tag),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_data     (cdb_data),
        .q_tag1       (q_tag1),
        .q_tag2       (q_tag2),
        .q_done1      (q_done1),
        .q_done2      (q_done2),
        .q_data1      (q_data1),
        .q_data2      (q_data2),
        .flush        (flush),
        .commit_valid (commit_valid),
        .commit_wen   (commit_wen),
        .commit_idx   (commit_idx),
        .commit_data  (commit_data),
        .commit_tag   (commit_tag),
        .empty        (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        flush;
        logic        av;
        logic [4:0]  rd;
        logic        wen;
        logic        cv;
        int          port;
        logic [2:0]  ctag;
        logic [31:0] cdata;
        logic        e_cv;
        logic        e_cw;
        logic [4:0]  e_idx;
        logic [31:0] e_data;
        logic [2:0]  e_tag;
        logic        e_ready;
        logic        e_empty;
        logic [2:0]  e_atag;
    } vec_t;

    vec_t vt [16];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        rst_n       = 1'b1;
        flush       = 1'b0;
        alloc_valid = 1'b0;
        alloc_rd    = '0;
        alloc_wen   = 1'b0;
        cdb_valid   = '0;
        cdb_tag     = '0;
        cdb_data    = '0;
    endtask

    task automatic set_cdb(input int p, input logic [2:0] t,
                           input logic [31:0] d);
        cdb_valid[p]         = 1'b1;
        cdb_tag[p*TW +: TW]  = t;
        cdb_data[p*32 +: 32] = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc_one(input logic [4:0] rd, input logic wen);
        idle();
        alloc_valid = 1'b1;
        alloc_rd    = rd;
        alloc_wen   = wen;
        step();
        idle();
    endtask

    task automatic chk_commit(input string nm, input logic v, input logic w,
                              input logic [4:0] idx, input logic [31:0] d,
                              input logic [2:0] t);
        chk({nm, ".cv"},   32'(commit_valid), 32'(v));
        chk({nm, ".cw"},   32'(commit_wen),   32'(w));
        chk({nm, ".idx"},  32'(commit_idx),   32'(idx));
        chk({nm, ".data"}, commit_data,       d);
        chk({nm, ".tag"},  32'(commit_tag),   32'(t));
    endtask

    initial begin
        idle();
        rst_n  = 1'b0;
        q_tag1 = '0;
        q_tag2 = '0;

        // rst flush av rd wen | cv port ctag cdata | cv cw idx data tag rdy emp atag
        vt[0]  = '{0,0,0, 0,0, 0,0,0,32'h0,  0,0,0,32'h0, 0,1,1,0};
        vt[1]  = '{1,0,1, 5,1, 0,0,0,32'h0,  0,0,0,32'h0, 0,1,0,1};
        vt[2]  = '{1,0,0, 0,0, 1,0,0,32'h11, 0,0,0,32'h0, 0,1,0,1};
        vt[3]  = '{1,0,0, 0,0, 0,0,0,32'h0,  1,1,5,32'h11,0,1,1,1};
        vt[4]  = '{1,0,0, 0,0, 0,0,0,32'h0,  0,0,5,32'h11,0,1,1,1};
        vt[5]  = '{1,0,1, 7,1, 0,0,0,32'h0,  0,0,5,32'h11,0,1,0,2};
        vt[6]  = '{1,0,1, 8,1, 0,0,0,32'h0,  0,0,5,32'h11,0,1,0,3};
        vt[7]  = '{1,0,0, 0,0, 1,2,2,32'h22, 0,0,5,32'h11,0,1,0,3};
        vt[8]  = '{1,0,0, 0,0, 0,0,0,32'h0,  0,0,5,32'h11,0,1,0,3};
        vt[9]  = '{1,0,0, 0,0, 1,3,1,32'h33, 0,0,5,32'h11,0,1,0,3};
        vt[10] = '{1,0,0, 0,0, 0,0,0,32'h0,  1,1,7,32'h33,1,1,0,3};
        vt[11] = '{1,0,0, 0,0, 0,0,0,32'h0,  1,1,8,32'h22,2,1,1,3};
        vt[12] = '{1,0,0, 0,0, 0,0,0,32'h0,  0,0,8,32'h22,2,1,1,3};
        vt[13] = '{1,0,1, 9,0, 0,0,0,32'h0,  0,0,8,32'h22,2,1,0,4};
        vt[14] = '{1,0,0, 0,0, 1,5,3,32'h44, 0,0,8,32'h22,2,1,0,4};
        vt[15] = '{1,0,0, 0,0, 0,0,0,32'h0,  1,0,9,32'h44,3,1,1,4};

        for (int i = 0; i < 16; i++) begin
            idle();
            rst_n       = vt[i].rst_n;
            flush       = vt[i].flush;
            alloc_valid = vt[i].av;
            alloc_rd    = vt[i].rd;
            alloc_wen   = vt[i].wen;
            if (vt[i].cv) set_cdb(vt[i].port, vt[i].ctag, vt[i].cdata);
            step();
            chk_commit($sformatf("v%0d", i), vt[i].e_cv, vt[i].e_cw,
                       vt[i].e_idx, vt[i].e_data, vt[i].e_tag);
            chk($sformatf("v%0d.ready", i), 32'(alloc_ready), 32'(vt[i].e_ready));
            chk($sformatf("v%0d.empty", i), 32'(empty), 32'(vt[i].e_empty));
            chk($sformatf("v%0d.atag", i), 32'(alloc_tag), 32'(vt[i].e_atag));
        end

        // Same-tag collision on two ports plus lookup bypass.
        alloc_one(5'd10, 1'b1);
        alloc_one(5'd11, 1'b1);
        alloc_one(5'd12, 1'b1);
        chk("pri.atag", 32'(alloc_tag), 32'd7);
        set_cdb(1, 3'd6, 32'hAA);
        set_cdb(4, 3'd6, 32'hBB);
        q_tag1 = 3'd6;
        q_tag2 = 3'd4;
        #1;
        chk("pri.byp_done", 32'(q_done1), 32'd1);
        chk("pri.byp_data", q_data1, 32'hAA);
        chk("pri.q2_done", 32'(q_done2), 32'd0);
        chk("pri.q2_data", q_data2, 32'h0);
        step();
        idle();
        #1;
        chk("pri.ent_done", 32'(q_done1), 32'd1);
        chk("pri.ent_data", q_data1, 32'hAA);
        set_cdb(0, 3'd4, 32'h10);
        set_cdb(2, 3'd5, 32'h20);
        step();
        idle();
        chk("pri.c0_cv", 32'(commit_valid), 32'd0);
        step();
        chk_commit("pri.c4", 1, 1, 5'd10, 32'h10, 3'd4);
        step();
        chk_commit("pri.c5", 1, 1, 5'd11, 32'h20, 3'd5);
        step();
        chk_commit("pri.c6", 1, 1, 5'd12, 32'hAA, 3'd6);
        chk("pri.empty", 32'(empty), 32'd1);

        // Fill to capacity from head=tail=0, then drain with wrap.
        idle();
        rst_n = 1'b0;
        step();
        idle();
        chk("full.rst_ready", 32'(alloc_ready), 32'd1);
        chk("full.rst_empty", 32'(empty), 32'd1);
        for (int i = 0; i < 8; i++) alloc_one(5'(i + 1), 1'b1);
        chk("full.ready", 32'(alloc_ready), 32'd0);
        chk("full.atag", 32'(alloc_tag), 32'd0);
        chk("full.empty", 32'(empty), 32'd0);
        for (int i = 0; i < 8; i++) begin
            idle();
            alloc_valid = (i < 2);
            alloc_rd    = 5'd31;
            alloc_wen   = 1'b1;
            set_cdb(0, 3'(i), 32'h100 + 32'(i));
            step();
            if (i == 0) begin
                chk("full.ninth_ready", 32'(alloc_ready), 32'd0);
                chk("full.ninth_atag", 32'(alloc_tag), 32'd0);
            end
            if (i == 1) begin
                chk("full.cmt_ready", 32'(alloc_ready), 32'd1);
                chk("full.cmt_atag", 32'(alloc_tag), 32'd0);
            end
            if (i >= 1) begin
                chk_commit($sformatf("full.c%0d", i - 1), 1, 1, 5'(i),
                           32'h100 + 32'(i - 1), 3'(i - 1));
            end
        end
        idle();
        step();
        chk_commit("full.c7", 1, 1, 5'd8, 32'h107, 3'd7);
        chk("full.end_empty", 32'(empty), 32'd1);
        chk("full.end_atag", 32'(alloc_tag), 32'd0);
        step();
        chk("full.after_cv", 32'(commit_valid), 32'd0);

        // Flush with a completed head and a bus hit in flight.
        for (int i = 0; i < 5; i++) alloc_one(5'(i + 1), 1'b1);
        chk("fl.atag_pre", 32'(alloc_tag), 32'd5);
        set_cdb(0, 3'd0, 32'h77);
        step();
        idle();
        flush       = 1'b1;
        alloc_valid = 1'b1;
        alloc_rd    = 5'd20;
        set_cdb(0, 3'd1, 32'h88);
        step();
        idle();
        chk("fl.empty", 32'(empty), 32'd1);
        chk("fl.cv", 32'(commit_valid), 32'd0);
        chk("fl.atag", 32'(alloc_tag), 32'd0);
        chk("fl.ready", 32'(alloc_ready), 32'd1);
        q_tag1 = 3'd0;
        #1;
        chk("fl.q_done", 32'(q_done1), 32'd0);
        step();
        chk("fl.next_cv", 32'(commit_valid), 32'd0);

        // Reset mid-stream behaves like flush and clears the commit port.
        for (int i = 0; i < 3; i++) alloc_one(5'(i + 3), 1'b1);
        set_cdb(0, 3'd0, 32'h99);
        step();
        idle();
        rst_n       = 1'b0;
        alloc_valid = 1'b1;
        set_cdb(0, 3'd1, 32'h55);
        step();
        idle();
        chk("rs.empty", 32'(empty), 32'd1);
        chk("rs.atag", 32'(alloc_tag), 32'd0);
        chk("rs.ready", 32'(alloc_ready), 32'd1);
        chk_commit("rs", 0, 0, 5'd0, 32'h0, 3'd0);
        step();
        chk("rs.next_cv", 32'(commit_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameters: DEPTH, 8, number of entries (power of 2); TAG_W, 3, log2(DEPTH); NCDB, 6, result-bus ports (ADD1-3, MULT1-2, LS).
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 alloc_valid  in  1  issue stage requests an entry this cycle.
REQ-005 alloc_rd  in  5  destination register of the issuing instruction.
REQ-006 alloc_wen  in  1  instruction writes a register (0 for stores).
REQ-007 alloc_ready  out  1  entry available (count < DEPTH); combinational.
REQ-008 alloc_tag  out  TAG_W  entry index granted (current tail); combinational.
REQ-009 cdb_valid  in  NCDB  per-port result valid.
REQ-010 cdb_tag  in  NCDB*TAG_W  per-port ROB tag, port p at bits [p*TAG_W +: TAG_W].
REQ-011 cdb_data  in  NCDB*32  per-port result, port p at bits [p*32 +: 32].
REQ-012 q_tag1, q_tag2  in  TAG_W each  operand lookup tags.
REQ-013 q_done1, q_done2  out  1 each  looked-up entry is busy and has a result.
REQ-014 q_data1, q_data2  out  32 each  looked-up result.
REQ-015 flush  in  1  discard all entries.
REQ-016 commit_valid  out  1  one entry retired last edge (registered).
REQ-017 commit_wen  out  1  register write enable to regfile (registered).
REQ-018 commit_idx  out  5  destination register (registered).
REQ-019 commit_data  out  32  value to write (registered).
REQ-020 commit_tag  out  TAG_W  tag retired, for rename-table clear (registered).
REQ-021 empty  out  1  count == 0.

Function
REQ-022 Per entry state: busy, done, wen, rd[4:0], data[31:0]; pointers head, tail (TAG_W, wrap modulo DEPTH); count (TAG_W+1 bits).
REQ-023 Allocation: alloc_valid && alloc_ready -> entry[tail] busy=1, done=0, rd/wen captured; tail+1.
REQ-024 alloc_ready is based on count only; a full ROB does not accept in the same cycle as a commit.
REQ-025 CDB capture: each valid port whose tag matches a busy entry sets done=1 and data=cdb_data; a port targeting a non-busy entry is ignored.
REQ-026 Several ports with the same tag in one cycle: lowest port index wins.
REQ-027 Commit: at an edge where entry[head] is busy and done, clear busy, head+1, register commit_valid=1, commit_wen=entry.wen, commit_idx, commit_data, commit_tag=head; otherwise commit_valid=commit_wen=0 and other commit outputs hold.
REQ-028 At most one commit per cycle; strictly in order.
REQ-029 Latency: a result captured from the CDB at edge N commits no earlier than edge N+1; commit outputs are visible after that edge.
REQ-030 count' = count + alloc_fire - commit_fire; simultaneous alloc and commit leaves count unchanged.
REQ-031 Lookup: q_doneX=1 and q_dataX from a matching valid CDB port this cycle (REQ-026 priority); else from entry[q_tagX] if busy and done; else q_doneX=0, q_dataX=0.
REQ-032 flush has priority over alloc, CDB and commit: all busy cleared, head=tail=count=0, commit_valid=commit_wen=0 next cycle.

Reset
REQ-033 While rst_n=0 at an edge: head=tail=count=0; all busy/done=0; commit_valid=commit_wen=0, commit_idx=0, commit_data=0, commit_tag=0.
REQ-034 Reset mid-operation discards all entries; alloc_ready=1 and empty=1 on the first cycle after reset release.

Structure
REQ-035 DEPTH, TAG_W, NCDB and the CDB port index constants (ADD1=0..LS=5) live in the shared core package used by the rename and reservation-station logic.
REQ-036 One sub-module, rob_cdb_match, performs per-entry priority tag matching across NCDB ports; used for both capture and lookup bypass.

Verification
REQ-037 Alloc rd=5 wen=1 (tag 0); CDB port 0 tag 0 data 0x11 -> next edge commit_valid=1, commit_wen=1, idx=5, data=0x11, tag=0.
REQ-038 Alloc tags 0,1; complete tag 1 (0x22), then tag 0 (0x33) two cycles later -> tag 0 commits first with 0x33, tag 1 next cycle with 0x22.
REQ-039 Allocate 8 without completion -> alloc_ready=0 and count=8; 9th request ignored; complete all -> 8 consecutive commits, then empty=1 and tail/head wrapped to 0.
REQ-040 Ports 1 and 4 both tag 2, data 0xAA/0xBB same cycle -> entry 2 stores 0xAA; q_tag1=2 same cycle returns q_done1=1, q_data1=0xAA.
REQ-041 Alloc wen=0 store, complete it -> commit_valid=1, commit_wen=0.
REQ-042 flush with 5 entries and a CDB hit pending -> next cycle empty=1, commit_valid=0, alloc_tag=0; same for rst_n=0 mid-stream.
